// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle sequencer for conditional branches (beq, bne, blez, bgtz)
// in the MIPS multi-cycle core. After a start from the main control FSM it drives the ALU
// through a target computation cycle and a compare cycle, then resolves the branch.
//
// Ports:
//   clk_i            system clock, rising edge
//   reset_i          asynchronous active-high reset
//   start_i          one-cycle request from the main FSM, sampled only in IDLE
//   opcode_i         instruction[31:26], sampled with start_i
//   cond_in_i        branch-condition mux output (selected by branch_ctrl_o)
//   clear_counts_i   synchronous clear of both statistics counters
//   alu_src_a_o      0 = PC, 1 = register A
//   alu_src_b_o      00 = reg B, 01 = 4, 10 = 0, 11 = sign-extended offset << 2
//   alu_op_o         010 add, 110 sub, 000 idle
//   aluout_load_o    ALUOut register write enable
//   branch_ctrl_o    condition mux select: 00 bne, 01 blez, 10 beq, 11 bgtz
//   pc_write_cond_o  PCWriteCond
//   pc_source_o      1 = ALUOut to PC
//   busy_o           high in any state except IDLE
//   done_o           one-cycle pulse in FINISH or ERR
//   illegal_o        one-cycle pulse in ERR
//   taken_o          registered resolution of the last branch
//   taken_count_o    saturating count of taken branches
//   nottaken_count_o saturating count of not-taken branches
module branch_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [5:0]       opcode_i,
    input  logic             cond_in_i,
    input  logic             clear_counts_i,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             aluout_load_o,
    output logic [1:0]       branch_ctrl_o,
    output logic             pc_write_cond_o,
    output logic             pc_source_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             illegal_o,
    output logic             taken_o,
    output logic [CNT_W-1:0] taken_count_o,
    output logic [CNT_W-1:0] nottaken_count_o
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StTarget  = 3'd1,
        StCompare = 3'd2,
        StFinish  = 3'd3,
        StErr     = 3'd4
    } state_e;

    localparam logic [2:0] AluAdd  = 3'b010;
    localparam logic [2:0] AluSub  = 3'b110;
    localparam logic [2:0] AluIdle = 3'b000;

    state_e           state_q, state_d;
    logic [1:0]       branch_ctrl_q, branch_ctrl_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            branch_ctrl_q  <= 2'b00;
            taken_q        <= 1'b0;
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            branch_ctrl_q  <= branch_ctrl_d;
            taken_q        <= taken_d;
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    // Next state and latched condition select
    always_comb begin
        state_d       = state_q;
        branch_ctrl_d = branch_ctrl_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StTarget;
                    case (opcode_i)
                        6'h04:   branch_ctrl_d = 2'b10; // beq
                        6'h05:   branch_ctrl_d = 2'b00; // bne
                        6'h06:   branch_ctrl_d = 2'b01; // blez
                        6'h07:   branch_ctrl_d = 2'b11; // bgtz
                        default: state_d       = StErr; // select left untouched
                    endcase
                end
            end
            StTarget:  state_d = StCompare;
            StCompare: state_d = StFinish;
            StFinish:  state_d = StIdle;
            StErr:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Resolution and saturating statistics; clear wins over a same-edge increment
    always_comb begin
        taken_d        = taken_q;
        taken_cnt_d    = taken_cnt_q;
        nottaken_cnt_d = nottaken_cnt_q;
        if (state_q == StCompare) begin
            taken_d = cond_in_i;
            if (cond_in_i) begin
                if (taken_cnt_q != {CNT_W{1'b1}}) begin
                    taken_cnt_d = taken_cnt_q + CNT_W'(1);
                end
            end else begin
                if (nottaken_cnt_q != {CNT_W{1'b1}}) begin
                    nottaken_cnt_d = nottaken_cnt_q + CNT_W'(1);
                end
            end
        end
        if (clear_counts_i) begin
            taken_cnt_d    = '0;
            nottaken_cnt_d = '0;
        end
    end

    // Moore output decode: depends only on state_q and branch_ctrl_q
    always_comb begin
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = AluIdle;
        aluout_load_o   = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = 1'b0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        illegal_o       = 1'b0;
        unique case (state_q)
            StIdle: ;
            StTarget: begin
                busy_o        = 1'b1;
                alu_src_b_o   = 2'b11;
                alu_op_o      = AluAdd;
                aluout_load_o = 1'b1;
            end
            StCompare: begin
                busy_o          = 1'b1;
                alu_src_a_o     = 1'b1;
                // beq/bne compare against B; blez/bgtz compare against zero
                alu_src_b_o     = branch_ctrl_q[0] ? 2'b10 : 2'b00;
                if (branch_ctrl_q == 2'b00 || branch_ctrl_q == 2'b10) begin
                    alu_src_b_o = 2'b00;
                end
                alu_op_o        = AluSub;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 1'b1;
            end
            StFinish: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            StErr: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                illegal_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign branch_ctrl_o    = branch_ctrl_q;
    assign taken_o          = taken_q;
    assign taken_count_o    = taken_cnt_q;
    assign nottaken_count_o = nottaken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [5:0]       opcode;
    logic             cond_in;
    logic             clear_counts;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             aluout_load;
    logic [1:0]       branch_ctrl;
    logic             pc_write_cond;
    logic             pc_source;
    logic             busy;
    logic             done;
    logic             illegal;
    logic             taken;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] nottaken_count;

    int tests;
    int fails;

    branch_sequencer #(.CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .opcode_i         (opcode),
        .cond_in_i        (cond_in),
        .clear_counts_i   (clear_counts),
        .alu_src_a_o      (alu_src_a),
        .alu_src_b_o      (alu_src_b),
        .alu_op_o         (alu_op),
        .aluout_load_o    (aluout_load),
        .branch_ctrl_o    (branch_ctrl),
        .pc_write_cond_o  (pc_write_cond),
        .pc_source_o      (pc_source),
        .busy_o           (busy),
        .done_o           (done),
        .illegal_o        (illegal),
        .taken_o          (taken),
        .taken_count_o    (taken_count),
        .nottaken_count_o (nottaken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: runs one branch from IDLE back to IDLE, inputs changed at negedges.
    task automatic run_branch(input logic [5:0] op, input logic c, input logic clr);
        @(negedge clk);
        start = 1'b1; opcode = op;
        @(negedge clk);                 // TARGET
        start = 1'b0; cond_in = c;
        @(negedge clk);                 // COMPARE
        clear_counts = clr;
        @(negedge clk);                 // FINISH
        clear_counts = 1'b0;
        cond_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        @(negedge clk);
        tests++;
        if ({busy, done, illegal, pc_write_cond, aluout_load, pc_source, alu_src_a} !== 7'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b expected 0000000",
                     {busy, done, illegal, pc_write_cond, aluout_load, pc_source, alu_src_a});
        end
        tests++;
        if ({alu_src_b, alu_op, branch_ctrl, taken, taken_count, nottaken_count} !== 12'b0) begin
            fails++;
            $display("FAIL reset_values: srcb=%b op=%b ctrl=%b taken=%b tc=%0d nc=%0d expected 0",
                     alu_src_b, alu_op, branch_ctrl, taken, taken_count, nottaken_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_beq();
        @(negedge clk);
        start = 1'b1; opcode = 6'h04;
        @(negedge clk);                 // TARGET
        start = 1'b0; cond_in = 1'b1;
        tests++;
        if ({branch_ctrl, alu_src_a, alu_src_b, alu_op, aluout_load, pc_write_cond, busy}
            !== {2'b10, 1'b0, 2'b11, 3'b010, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL beq_target: ctrl=%b a=%b b=%b op=%b ld=%b pwc=%b busy=%b expected 10 0 11 010 1 0 1",
                     branch_ctrl, alu_src_a, alu_src_b, alu_op, aluout_load, pc_write_cond, busy);
        end
        @(negedge clk);                 // COMPARE
        tests++;
        if ({alu_src_a, alu_src_b, alu_op, aluout_load, pc_write_cond, pc_source, done}
            !== {1'b1, 2'b00, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL beq_compare: a=%b b=%b op=%b ld=%b pwc=%b psrc=%b done=%b expected 1 00 110 0 1 1 0",
                     alu_src_a, alu_src_b, alu_op, aluout_load, pc_write_cond, pc_source, done);
        end
        @(negedge clk);                 // FINISH
        cond_in = 1'b0;
        tests++;
        if ({done, illegal, taken, taken_count, nottaken_count} !== {1'b1, 1'b0, 1'b1, 2'd1, 2'd0}) begin
            fails++;
            $display("FAIL beq_finish: done=%b ill=%b taken=%b tc=%0d nc=%0d expected 1 0 1 1 0",
                     done, illegal, taken, taken_count, nottaken_count);
        end
        @(negedge clk);                 // IDLE
        tests++;
        if ({busy, done, taken} !== 3'b001) begin
            fails++;
            $display("FAIL beq_idle: busy=%b done=%b taken=%b expected 0 0 1", busy, done, taken);
        end
    endtask

    task automatic test_bgtz();
        @(negedge clk);
        start = 1'b1; opcode = 6'h07;
        @(negedge clk);                 // TARGET
        start = 1'b0; cond_in = 1'b0;
        tests++;
        if (branch_ctrl !== 2'b11) begin
            fails++;
            $display("FAIL bgtz_ctrl: got %b expected 11", branch_ctrl);
        end
        @(negedge clk);                 // COMPARE
        tests++;
        if ({alu_src_b, alu_op, pc_write_cond} !== {2'b10, 3'b110, 1'b1}) begin
            fails++;
            $display("FAIL bgtz_compare: b=%b op=%b pwc=%b expected 10 110 1",
                     alu_src_b, alu_op, pc_write_cond);
        end
        @(negedge clk);                 // FINISH
        tests++;
        if ({done, taken, taken_count, nottaken_count} !== {1'b1, 1'b0, 2'd1, 2'd1}) begin
            fails++;
            $display("FAIL bgtz_finish: done=%b taken=%b tc=%0d nc=%0d expected 1 0 1 1",
                     done, taken, taken_count, nottaken_count);
        end
    endtask

    task automatic test_illegal();
        int bad_strobe;
        bad_strobe = 0;
        @(negedge clk);
        start = 1'b1; opcode = 6'h23;
        @(negedge clk);                 // ERR
        start = 1'b0;
        if (pc_write_cond || aluout_load) bad_strobe++;
        tests++;
        if ({done, illegal, busy} !== 3'b111) begin
            fails++;
            $display("FAIL illegal_err: done=%b ill=%b busy=%b expected 1 1 1", done, illegal, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pc_write_cond || aluout_load || done) bad_strobe++;
        end
        tests++;
        if (bad_strobe !== 0) begin
            fails++;
            $display("FAIL illegal_strobes: got %0d stray strobes expected 0", bad_strobe);
        end
        tests++;
        if ({branch_ctrl, taken_count, nottaken_count} !== {2'b11, 2'd1, 2'd1}) begin
            fails++;
            $display("FAIL illegal_state: ctrl=%b tc=%0d nc=%0d expected 11 1 1",
                     branch_ctrl, taken_count, nottaken_count);
        end
    endtask

    task automatic test_back_to_back();
        int done_seen;
        done_seen = 0;
        // bne held through IDLE, TARGET and COMPARE sample points
        @(negedge clk);
        start = 1'b1; opcode = 6'h05; cond_in = 1'b0;
        @(negedge clk);                 // TARGET
        @(negedge clk);                 // COMPARE
        @(negedge clk);                 // FINISH
        if (done) done_seen++;
        tests++;
        if (branch_ctrl !== 2'b00) begin
            fails++;
            $display("FAIL b2b_ctrl: got %b expected 00", branch_ctrl);
        end
        // start still high on the FINISH cycle: must be dropped
        opcode = 6'h04;
        @(negedge clk);                 // IDLE
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_finish_start: busy=%b expected 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        tests++;
        if (done_seen !== 1 || nottaken_count !== 2'd2) begin
            fails++;
            $display("FAIL b2b_single_done: dones=%0d nc=%0d expected 1 2", done_seen, nottaken_count);
        end
        // next start in IDLE: blez, taken
        @(negedge clk);
        start = 1'b1; opcode = 6'h06;
        @(negedge clk);                 // TARGET
        start = 1'b0; cond_in = 1'b1;
        @(negedge clk);                 // COMPARE
        tests++;
        if ({branch_ctrl, alu_src_b} !== {2'b01, 2'b10}) begin
            fails++;
            $display("FAIL blez_compare: ctrl=%b b=%b expected 01 10", branch_ctrl, alu_src_b);
        end
        @(negedge clk);                 // FINISH
        cond_in = 1'b0;
        tests++;
        if ({done, taken, taken_count} !== {1'b1, 1'b1, 2'd2}) begin
            fails++;
            $display("FAIL blez_finish: done=%b taken=%b tc=%0d expected 1 1 2",
                     done, taken, taken_count);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        @(negedge clk);
        start = 1'b1; opcode = 6'h04;
        @(negedge clk);                 // TARGET
        start = 1'b0; cond_in = 1'b1;
        @(negedge clk);                 // COMPARE
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({busy, pc_write_cond, alu_op, alu_src_b, branch_ctrl, taken, taken_count, nottaken_count}
            !== 14'b0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b pwc=%b op=%b b=%b ctrl=%b taken=%b tc=%0d nc=%0d expected 0",
                     busy, pc_write_cond, alu_op, alu_src_b, branch_ctrl, taken, taken_count,
                     nottaken_count);
        end
        @(negedge clk);
        reset = 1'b0; cond_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || pc_write_cond || busy) stray++;
        end
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL reset_mid_after: got %0d stray cycles expected 0", stray);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            run_branch(6'h04, 1'b1, 1'b0);
        end
        tests++;
        if (taken_count !== 2'd3) begin
            fails++;
            $display("FAIL sat_count: got %0d expected 3", taken_count);
        end
        run_branch(6'h04, 1'b1, 1'b1);
        tests++;
        if ({taken_count, nottaken_count, taken} !== {2'd0, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL clear_priority: tc=%0d nc=%0d taken=%b expected 0 0 1",
                     taken_count, nottaken_count, taken);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        start = 1'b0;
        opcode = 6'h00;
        cond_in = 1'b0;
        clear_counts = 1'b0;
        reset = 1'b0;
        test_reset();
        test_beq();
        test_bgtz();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle controller for conditional branches (beq, bne, blez, bgtz) in the MIPS multi-cycle core.
- Started by the main control FSM in decode. Over two cycles it sequences the ALU: first target computation, then comparison.
- Drives the 2-bit BranchCtrl select of the branch-condition mux and reads the mux output back.
- Asserts PCWriteCond on the resolve cycle and keeps saturating taken/not-taken statistics.

Parameters:
CNT_W, 16, width of each taken/not-taken statistics counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request from main FSM; sampled only in IDLE
opcode  in  6  instruction[31:26], sampled with start
cond_in  in  1  branch-condition mux output (registered datapath flags selected by branch_ctrl)
clear_counts  in  1  synchronous clear of both statistics counters
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  00=register B, 01=const 4, 10=const 0, 11=sign-ext offset<<2
alu_op  out  3  3'b010 add, 3'b110 sub, 3'b000 when idle
aluout_load  out  1  write enable of ALUOut register
branch_ctrl  out  2  select to condition mux: 00 bne, 01 blez, 10 beq, 11 bgtz
pc_write_cond  out  1  PCWriteCond; PC written when high and cond_in high
pc_source  out  1  1=ALUOut to PC
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse in FINISH or ERR
illegal  out  1  one-cycle pulse in ERR
taken  out  1  registered resolution of last branch; valid from FINISH until next start
taken_count  out  CNT_W  saturating count of taken branches
nottaken_count  out  CNT_W  saturating count of not-taken branches

Behaviour:

States and transitions:
- States: IDLE, TARGET, COMPARE, FINISH, ERR (binary encoded).
- IDLE: on start with opcode 0x04/0x05/0x06/0x07, latch branch_ctrl (0x04->10, 0x05->00, 0x06->01, 0x07->11) and go to TARGET. On start with any other opcode, go to ERR and leave branch_ctrl unchanged. Without start, stay in IDLE.
- TARGET (1 cycle): alu_src_a=0, alu_src_b=11, alu_op=add, aluout_load=1. Next state: COMPARE.
- COMPARE (1 cycle): alu_src_a=1, alu_op=sub, aluout_load=0, pc_write_cond=1, pc_source=1.
  - alu_src_b=00 for beq/bne; alu_src_b=10 for blez/bgtz.
  - At the end of the cycle, register cond_in into taken and increment the matching counter.
  - Next state: FINISH.
- FINISH (1 cycle): done=1. Next state: IDLE.
- ERR (1 cycle): done=1, illegal=1, no PC/ALUOut write. Next state: IDLE.

Latency and start rules:
- Start to done is 3 cycles for a legal branch and 1 cycle for an illegal opcode.
- start asserted outside IDLE is ignored (not queued). start on the FINISH cycle is also dropped; the next start is accepted on the following IDLE cycle.

Output decode and reset:
- All control outputs are Moore-decoded from state plus latched branch_ctrl, with no combinational path from start.
- Outside the listed states, every strobe is 0, alu_op=000 and the mux selects are 0.
- branch_ctrl holds its latched value between branches.
- Reset values (asynchronous): state=IDLE, branch_ctrl=00, taken=0, both counters=0, all strobes=0.
- Reset asserted mid-branch aborts immediately. No pc_write_cond or done is produced after reset deassertion until a new start.

Counters:
- Saturate at 2^CNT_W-1 and do not wrap.
- clear_counts has priority over a simultaneous increment: the result is 0 on that edge.
- clear_counts is accepted in any state.

Test Plan:
- beq (opcode 0x04), cond_in=1 in COMPARE -> branch_ctrl=10; TARGET cycle alu_src_b=11/alu_op=010/aluout_load=1; COMPARE cycle pc_write_cond=1, alu_src_b=00, alu_op=110; done on 3rd cycle after start; taken=1; taken_count 0->1.
- bgtz (0x07), cond_in=0 -> branch_ctrl=11, alu_src_b=10 in COMPARE, taken=0, nottaken_count=1, taken_count unchanged.
- Illegal opcode 0x23 with start -> next cycle done=1 and illegal=1; pc_write_cond and aluout_load never asserted; counters unchanged; branch_ctrl unchanged.
- start re-asserted during TARGET and COMPARE -> ignored; exactly one done; the next start in IDLE completes normally.
- Reset asserted during COMPARE -> state IDLE immediately, all outputs 0, counters 0; no done observed afterwards.
- CNT_W=2: four taken branches -> taken_count stays 3. Then clear_counts coincident with a COMPARE edge -> taken_count=0.
